// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared register-file geometry and writeback entry type
package cpu_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;
  localparam int WB_ENTRY_W = REG_ADDR_W + DATA_W;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - power-of-two FIFO holding load results awaiting the write port
module wb_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CNT_W-1:0] count
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full, empty, push_ok, pop_ok;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  // A push while full is refused even if a pop frees a slot this cycle.
  assign push_ok   = push && !full;
  assign pop_ok    = pop && !empty;
  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - single register-file write port shared by ALU (priority) and buffered loads
module wb_arbiter
  import cpu_pkg::*;
#(
  parameter int LD_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_waddr,
  input  logic [DATA_W-1:0]     alu_wdata,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [REG_ADDR_W-1:0] ld_waddr,
  input  logic [DATA_W-1:0]     ld_wdata,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_waddr,
  input  logic [REG_ADDR_W-1:0] chk_addr1,
  input  logic [REG_ADDR_W-1:0] chk_addr2,
  output logic                  busy1,
  output logic                  busy2,
  output logic                  we,
  output logic [REG_ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0]     wdata
);
  localparam int CNT_W = $clog2(LD_DEPTH) + 1;

  wb_entry_t             ld_entry, head_entry;
  logic [CNT_W-1:0]      ld_count;
  logic                  fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic                  we_q, we_d;
  logic [REG_ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [NUM_REGS-1:0]   pending_q, pending_d;

  assign ld_entry   = '{addr: ld_waddr, data: ld_wdata};
  assign fifo_full  = (ld_count == CNT_W'(LD_DEPTH));
  assign fifo_empty = (ld_count == '0);
  assign ld_ready   = rst && !fifo_full;
  assign fifo_push  = ld_valid && ld_ready;
  assign fifo_pop   = rst && !alu_valid && !fifo_empty;

  wb_fifo #(
    .WIDTH(WB_ENTRY_W),
    .DEPTH(LD_DEPTH)
  ) u_ld_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_data(ld_entry),
    .pop      (fifo_pop),
    .head_data(head_entry),
    .count    (ld_count)
  );

  always_comb begin
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    pending_d = pending_q;
    if (alu_valid) begin
      we_d    = (alu_waddr != '0);
      waddr_d = alu_waddr;
      wdata_d = alu_wdata;
    end else if (fifo_pop) begin
      we_d    = (head_entry.addr != '0);
      waddr_d = head_entry.addr;
      wdata_d = head_entry.data;
      pending_d[head_entry.addr] = 1'b0;
    end
    // Applied after the clear so a same-cycle issue to the popped register stays pending.
    if (issue_valid && issue_waddr != '0) begin
      pending_d[issue_waddr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      pending_q <= '0;
    end else begin
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      pending_q <= pending_d;
    end
  end

  assign we    = we_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;
  assign busy1 = pending_q[chk_addr1] && (chk_addr1 != '0);
  assign busy2 = pending_q[chk_addr2] && (chk_addr2 != '0);
endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - vector table, directed corner sequences and a per-cycle scoreboard for wb_arbiter
module tb_wb_arbiter;
  localparam int LD_DEPTH = 4;
  localparam int NV = 17;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, ld_valid, ld_ready, issue_valid;
  logic [4:0]  alu_waddr, ld_waddr, issue_waddr, chk_addr1, chk_addr2, waddr;
  logic [31:0] alu_wdata, ld_wdata, wdata;
  logic        busy1, busy2, we;

  int checks = 0;
  int errors = 0;

  wb_arbiter #(.LD_DEPTH(LD_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_waddr(ld_waddr), .ld_wdata(ld_wdata),
    .issue_valid(issue_valid), .issue_waddr(issue_waddr),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2), .busy1(busy1), .busy2(busy2),
    .we(we), .waddr(waddr), .wdata(wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, want %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: loads queue up in acceptance order, each edge yields one expected write.
  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        ld_q[$];
  logic [31:0] pend_m   = '0;
  logic        exp_we   = 1'b0;
  logic [4:0]  exp_wa   = '0;
  logic [31:0] exp_wd   = '0;
  logic        exp_data = 1'b0;
  logic        mon_en   = 1'b0;

  always @(posedge clk) begin : model
    ent_t e;
    int   occ;
    if (!rst) begin
      ld_q.delete();
      pend_m   = '0;
      exp_we   = 1'b0;
      exp_wa   = '0;
      exp_wd   = '0;
      exp_data = 1'b1;
      mon_en   = 1'b1;
    end else begin
      occ = ld_q.size();
      if (alu_valid) begin
        exp_we   = (alu_waddr != 5'd0);
        exp_wa   = alu_waddr;
        exp_wd   = alu_wdata;
        exp_data = 1'b1;
      end else if (occ > 0) begin
        e        = ld_q.pop_front();
        exp_we   = (e.a != 5'd0);
        exp_wa   = e.a;
        exp_wd   = e.d;
        exp_data = 1'b1;
        pend_m[e.a] = 1'b0;
      end else begin
        exp_we   = 1'b0;
        exp_data = 1'b0;
      end
      if (issue_valid && issue_waddr != 5'd0) pend_m[issue_waddr] = 1'b1;
      if (ld_valid && occ < LD_DEPTH) ld_q.push_back('{ld_waddr, ld_wdata});
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk_bit("mon_we", we, exp_we);
      if (exp_data) begin
        chk("mon_waddr", 32'(waddr), 32'(exp_wa));
        chk("mon_wdata", wdata, exp_wd);
      end
      chk_bit("mon_ld_ready", ld_ready, rst && (ld_q.size() < LD_DEPTH));
      chk_bit("mon_busy1", busy1, pend_m[chk_addr1] && chk_addr1 != 5'd0);
      chk_bit("mon_busy2", busy2, pend_m[chk_addr2] && chk_addr2 != 5'd0);
    end
  end

  typedef struct packed {
    logic        av; logic [4:0] aa; logic [31:0] ad;
    logic        lv; logic [4:0] la; logic [31:0] ld;
    logic        iv; logic [4:0] ia;
    logic [4:0]  c1; logic [4:0] c2;
    logic        rdy; logic b1; logic b2;
    logic        ewe; logic [4:0] ewa; logic [31:0] ewd; logic cd;
  } vec_t;

  vec_t tv [NV];

  task automatic apply(input vec_t v);
    alu_valid   = v.av; alu_waddr = v.aa; alu_wdata = v.ad;
    ld_valid    = v.lv; ld_waddr  = v.la; ld_wdata  = v.ld;
    issue_valid = v.iv; issue_waddr = v.ia;
    chk_addr1   = v.c1; chk_addr2 = v.c2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1);
  end

  initial begin
    // ALU-only write, then an issued load r5 retiring two cycles after acceptance.
    tv[0]  = '{1'b1,5'd3,32'h12345678, 1'b0,5'd0,32'h0,        1'b0,5'd0, 5'd3,5'd0, 1'b1,1'b0,1'b0, 1'b1,5'd3,32'h12345678,1'b1};
    tv[1]  = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        1'b0,5'd0, 5'd3,5'd0, 1'b1,1'b0,1'b0, 1'b0,5'd0,32'h0,1'b0};
    tv[2]  = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        1'b1,5'd5, 5'd5,5'd3, 1'b1,1'b0,1'b0, 1'b0,5'd0,32'h0,1'b0};
    tv[3]  = '{1'b0,5'd0,32'h0,        1'b1,5'd5,32'hDEADBEEF, 1'b0,5'd0, 5'd5,5'd7, 1'b1,1'b1,1'b0, 1'b0,5'd0,32'h0,1'b0};
    tv[4]  = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        1'b0,5'd0, 5'd5,5'd0, 1'b1,1'b1,1'b0, 1'b1,5'd5,32'hDEADBEEF,1'b1};
    tv[5]  = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        1'b0,5'd0, 5'd5,5'd0, 1'b1,1'b0,1'b0, 1'b0,5'd0,32'h0,1'b0};
    // ALU held three cycles while load r7 waits in the FIFO.
    tv[6]  = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        1'b1,5'd7, 5'd7,5'd5, 1'b1,1'b0,1'b0, 1'b0,5'd0,32'h0,1'b0};
    tv[7]  = '{1'b1,5'd1,32'h11,       1'b1,5'd7,32'h77,       1'b0,5'd0, 5'd7,5'd5, 1'b1,1'b1,1'b0, 1'b1,5'd1,32'h11,1'b1};
    tv[8]  = '{1'b1,5'd2,32'h22,       1'b0,5'd0,32'h0,        1'b0,5'd0, 5'd7,5'd0, 1'b1,1'b1,1'b0, 1'b1,5'd2,32'h22,1'b1};
    tv[9]  = '{1'b1,5'd3,32'h33,       1'b0,5'd0,32'h0,        1'b0,5'd0, 5'd7,5'd0, 1'b1,1'b1,1'b0, 1'b1,5'd3,32'h33,1'b1};
    tv[10] = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        1'b0,5'd0, 5'd7,5'd0, 1'b1,1'b1,1'b0, 1'b1,5'd7,32'h77,1'b1};
    tv[11] = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        1'b0,5'd0, 5'd7,5'd0, 1'b1,1'b0,1'b0, 1'b0,5'd0,32'h0,1'b0};
    // r0 from both sources: address/data update, write enable stays low, no busy.
    tv[12] = '{1'b1,5'd0,32'hAA,       1'b0,5'd0,32'h0,        1'b0,5'd0, 5'd0,5'd0, 1'b1,1'b0,1'b0, 1'b0,5'd0,32'hAA,1'b1};
    tv[13] = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        1'b1,5'd0, 5'd0,5'd0, 1'b1,1'b0,1'b0, 1'b0,5'd0,32'h0,1'b0};
    tv[14] = '{1'b0,5'd0,32'h0,        1'b1,5'd0,32'hBB,       1'b0,5'd0, 5'd0,5'd0, 1'b1,1'b0,1'b0, 1'b0,5'd0,32'h0,1'b0};
    tv[15] = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        1'b0,5'd0, 5'd0,5'd0, 1'b1,1'b0,1'b0, 1'b0,5'd0,32'hBB,1'b1};
    tv[16] = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,        1'b0,5'd0, 5'd0,5'd0, 1'b1,1'b0,1'b0, 1'b0,5'd0,32'h0,1'b0};

    rst = 1'b0;
    apply('0);
    repeat (3) @(posedge clk);
    #1;
    chk_bit("reset_we", we, 1'b0);
    chk("reset_waddr", 32'(waddr), 32'h0);
    chk("reset_wdata", wdata, 32'h0);
    chk_bit("reset_ld_ready", ld_ready, 1'b0);
    chk_bit("reset_busy1", busy1, 1'b0);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      apply(tv[i]);
      @(negedge clk);
      chk_bit($sformatf("v%0d_ld_ready", i), ld_ready, tv[i].rdy);
      chk_bit($sformatf("v%0d_busy1", i), busy1, tv[i].b1);
      chk_bit($sformatf("v%0d_busy2", i), busy2, tv[i].b2);
      step();
      chk_bit($sformatf("v%0d_we", i), we, tv[i].ewe);
      if (tv[i].cd) begin
        chk($sformatf("v%0d_waddr", i), 32'(waddr), 32'(tv[i].ewa));
        chk($sformatf("v%0d_wdata", i), wdata, tv[i].ewd);
      end
    end

    // Fill the FIFO behind a continuous ALU stream, then drain in order.
    chk_addr1 = 5'd10;
    chk_addr2 = 5'd11;
    for (int i = 0; i < LD_DEPTH; i++) begin
      alu_valid = 1'b1; alu_waddr = 5'd1; alu_wdata = 32'h100 + i;
      ld_valid  = 1'b1; ld_waddr  = 5'(10 + i); ld_wdata = 32'hC0 + i;
      @(negedge clk);
      chk_bit("full_ready_filling", ld_ready, 1'b1);
      step();
    end
    ld_waddr = 5'd14; ld_wdata = 32'hC4; alu_wdata = 32'h200;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk_bit("full_ready_low", ld_ready, 1'b0);
      step();
    end
    alu_valid = 1'b0;
    @(negedge clk);
    chk_bit("full_ready_pop_same_cycle", ld_ready, 1'b0);
    step();
    chk("full_order_r10", 32'(waddr), 32'd10);
    @(negedge clk);
    chk_bit("full_ready_reopen", ld_ready, 1'b1);
    step();
    ld_valid = 1'b0;
    chk("full_order_r11", 32'(waddr), 32'd11);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_bit("full_drain_we", we, 1'b1);
      chk("full_drain_order", 32'(waddr), 32'(12 + i));
    end
    step();
    chk_bit("full_drained_idle", we, 1'b0);

    // Reset mid-run with two buffered loads and r5/r6 pending.
    chk_addr1 = 5'd5;
    chk_addr2 = 5'd6;
    issue_valid = 1'b1; issue_waddr = 5'd5; step();
    issue_waddr = 5'd6; step();
    issue_valid = 1'b0;
    alu_valid = 1'b1; alu_waddr = 5'd2; alu_wdata = 32'h300;
    ld_valid  = 1'b1; ld_waddr  = 5'd5; ld_wdata  = 32'h55;
    step();
    ld_waddr = 5'd6; ld_wdata = 32'h66; alu_wdata = 32'h301;
    step();
    chk_bit("rstmid_busy1_before", busy1, 1'b1);
    chk_bit("rstmid_busy2_before", busy2, 1'b1);
    rst = 1'b0;
    alu_wdata = 32'h302; ld_waddr = 5'd9; issue_valid = 1'b1; issue_waddr = 5'd9;
    @(negedge clk);
    chk_bit("rstmid_ld_ready_low", ld_ready, 1'b0);
    step();
    chk_bit("rstmid_we", we, 1'b0);
    chk("rstmid_waddr", 32'(waddr), 32'h0);
    chk("rstmid_wdata", wdata, 32'h0);
    chk_bit("rstmid_busy1", busy1, 1'b0);
    chk_bit("rstmid_busy2", busy2, 1'b0);
    rst = 1'b1;
    alu_valid = 1'b0; ld_valid = 1'b0; issue_valid = 1'b0;
    chk_addr1 = 5'd9;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk_bit("rstmid_no_stale_we", we, 1'b0);
      chk_bit("rstmid_r9_not_busy", busy1, 1'b0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
